// File: rtl/noc_pkg.sv
// Shared types for the NoC endpoint injection path.
package noc_pkg;
   localparam int NOC_FLIT_WIDTH = 256;
   localparam int NOC_DEST_WIDTH = 4;

   typedef struct packed {
      logic [NOC_FLIT_WIDTH-1:0] data;
      logic [NOC_DEST_WIDTH-1:0] dest;
      logic                      is_tail;
   } flit_t;

   typedef enum logic {HEAD = 1'b0, BODY = 1'b1} in_state_t;
endpackage

// File: rtl/noc_sync_fifo.sv
// Synchronous FIFO with registered storage; a written word becomes visible the cycle after the push.
module noc_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}};
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/noc_inject_adapter.sv
// Client-stream to NoC injection port: per-packet dest locking, flit buffering and
// credit-based flow control toward the router input buffer.
module noc_inject_adapter
   import noc_pkg::*;
#(
   parameter int FLIT_WIDTH        = NOC_FLIT_WIDTH,
   parameter int DEST_WIDTH        = NOC_DEST_WIDTH,
   parameter int FLIT_BUFFER_DEPTH = 2,
   parameter int FIFO_DEPTH        = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   output logic                  credit_err
);
   localparam int              CW       = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam int              FW       = FLIT_WIDTH + DEST_WIDTH + 1;
   localparam logic [CW-1:0]   CRED_MAX = CW'(FLIT_BUFFER_DEPTH);
   localparam logic [CW-1:0]   CRED_ONE = CW'(1);

   in_state_t             state_q, state_d;
   logic [DEST_WIDTH-1:0] dest_lock_q, dest_lock_d;
   logic [CW-1:0]         credits_q, credits_d;
   logic                  err_q, err_d;
   logic                  ready_q;
   logic                  send_q, send_d;
   logic [FLIT_WIDTH-1:0] data_q, data_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic                  tail_q, tail_d;

   logic                  fifo_full, fifo_empty, accept, pop;
   logic [DEST_WIDTH-1:0] wr_dest;
   logic [FW-1:0]         fifo_wdata, fifo_rdata;

   // ready_q holds in_ready low through reset and for the release cycle.
   assign in_ready   = ready_q && !fifo_full;
   assign accept     = in_valid && in_ready;
   assign pop        = !fifo_empty && (credits_q != '0);
   assign wr_dest    = (state_q == HEAD) ? in_dest : dest_lock_q;
   assign fifo_wdata = {in_data, wr_dest, in_last};

   noc_sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .wdata (fifo_wdata),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      dest_lock_d = dest_lock_q;
      if (accept) begin
         if (state_q == HEAD) dest_lock_d = in_dest;
         state_d = in_last ? HEAD : BODY;
      end
   end

   // A credit returned at the maximum count is a router protocol violation.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      case ({pop, credit_in})
         2'b10:   credits_d = credits_q - CRED_ONE;
         2'b01: begin
            if (credits_q == CRED_MAX) err_d = 1'b1;
            else                       credits_d = credits_q + CRED_ONE;
         end
         default: credits_d = credits_q;
      endcase
   end

   always_comb begin
      send_d = pop;
      data_d = data_q;
      dest_d = dest_q;
      tail_d = tail_q;
      if (pop) begin
         data_d = fifo_rdata[FW-1 -: FLIT_WIDTH];
         dest_d = fifo_rdata[DEST_WIDTH:1];
         tail_d = fifo_rdata[0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HEAD;
         dest_lock_q <= '0;
         credits_q   <= CRED_MAX;
         err_q       <= 1'b0;
         ready_q     <= 1'b0;
         send_q      <= 1'b0;
         data_q      <= '0;
         dest_q      <= '0;
         tail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         dest_lock_q <= dest_lock_d;
         credits_q   <= credits_d;
         err_q       <= err_d;
         ready_q     <= 1'b1;
         send_q      <= send_d;
         data_q      <= data_d;
         dest_q      <= dest_d;
         tail_q      <= tail_d;
      end
   end

   assign send_out    = send_q;
   assign data_out    = data_q;
   assign dest_out    = dest_q;
   assign is_tail_out = tail_q;
   assign credit_err  = err_q;
endmodule

// File: tb/tb_noc_inject_adapter.sv
// Bench for noc_inject_adapter: hand-checked vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_noc_inject_adapter;
   import noc_pkg::*;

   localparam int MAXC = 2;
   localparam int FD   = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [255:0] in_data;
   logic [3:0]   in_dest;
   logic         in_last, in_valid, in_ready;
   logic [255:0] data_out;
   logic [3:0]   dest_out;
   logic         is_tail_out, send_out, credit_in, credit_err;

   always #5 clk = ~clk;

   noc_inject_adapter #(.FLIT_WIDTH(256), .DEST_WIDTH(4), .FLIT_BUFFER_DEPTH(MAXC), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .dest_out(dest_out),
      .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in), .credit_err(credit_err)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: packets as a flit queue, credits as a plain integer.
   flit_t      mq[$];
   int         m_cred;
   logic       m_err, m_send, m_tail, m_ready, m_head;
   logic [255:0] m_data;
   logic [3:0] m_dest, m_lock;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_cred = MAXC; m_err = 0; m_send = 0; m_tail = 0; m_ready = 0;
      m_head = 1; m_data = '0; m_dest = '0; m_lock = '0;
   endtask

   task automatic check_model();
      chk("send_out", 256'(send_out), 256'(m_send));
      chk("data_out", data_out, m_data);
      chk("dest_out", 256'(dest_out), 256'(m_dest));
      chk("is_tail_out", 256'(is_tail_out), 256'(m_tail));
      chk("in_ready", 256'(in_ready), 256'(m_ready));
      chk("credit_err", 256'(credit_err), 256'(m_err));
      chk("credits", 256'(dut.credits_q), 256'(m_cred));
   endtask

   task automatic cycle(input logic v, input logic l, input logic [3:0] d,
                        input logic [255:0] dat, input logic cr);
      flit_t f;
      logic  acc, pop;
      @(negedge clk);
      in_valid = v; in_last = l; in_dest = d; in_data = dat; credit_in = cr;
      acc = v && m_ready;
      pop = (mq.size() > 0) && (m_cred > 0);
      if (pop) begin
         f = mq.pop_front();
         m_send = 1; m_data = f.data; m_dest = f.dest; m_tail = f.is_tail;
      end else m_send = 0;
      m_cred = m_cred - (pop ? 1 : 0) + (cr ? 1 : 0);
      if (m_cred > MAXC) begin m_cred = MAXC; m_err = 1; end
      if (acc) begin
         f.data = dat; f.dest = m_head ? d : m_lock; f.is_tail = l;
         if (m_head) m_lock = d;
         m_head = l;
         mq.push_back(f);
      end
      m_ready = (mq.size() < FD);
      @(posedge clk); #1;
      check_model();
   endtask

   typedef struct {
      logic v, l; logic [3:0] d; logic [7:0] dat; logic cr;
      logic e_send; logic [3:0] e_dest; logic e_tail; logic [7:0] e_data;
      logic e_ready, e_err; int e_cred;
   } vec_t;

   vec_t tbl[20];
   int   sends;

   initial begin
      // inputs: v l dest data cr | expected after edge: send dest tail data ready err credits
      tbl[0]  = '{1,1,4'd3,8'hA5,0, 0,4'd0,0,8'h00,1,0,2};
      tbl[1]  = '{0,0,4'd0,8'h00,0, 1,4'd3,1,8'hA5,1,0,1};
      tbl[2]  = '{0,0,4'd0,8'h00,1, 0,4'd3,1,8'hA5,1,0,2};
      tbl[3]  = '{1,0,4'd5,8'h10,0, 0,4'd3,1,8'hA5,1,0,2};
      tbl[4]  = '{1,0,4'd9,8'h11,0, 1,4'd5,0,8'h10,1,0,1};
      tbl[5]  = '{1,0,4'd9,8'h12,0, 1,4'd5,0,8'h11,1,0,0};
      tbl[6]  = '{1,1,4'd9,8'h13,0, 0,4'd5,0,8'h11,1,0,0};
      tbl[7]  = '{1,1,4'd7,8'h20,0, 0,4'd5,0,8'h11,1,0,0};
      tbl[8]  = '{1,1,4'd7,8'h21,0, 0,4'd5,0,8'h11,0,0,0};
      tbl[9]  = '{1,1,4'd7,8'h22,0, 0,4'd5,0,8'h11,0,0,0};
      tbl[10] = '{0,0,4'd0,8'h00,1, 0,4'd5,0,8'h11,0,0,1};
      tbl[11] = '{0,0,4'd0,8'h00,0, 1,4'd5,0,8'h12,1,0,0};
      tbl[12] = '{0,0,4'd0,8'h00,1, 0,4'd5,0,8'h12,1,0,1};
      tbl[13] = '{0,0,4'd0,8'h00,1, 1,4'd5,1,8'h13,1,0,1};
      tbl[14] = '{0,0,4'd0,8'h00,0, 1,4'd7,1,8'h20,1,0,0};
      tbl[15] = '{0,0,4'd0,8'h00,1, 0,4'd7,1,8'h20,1,0,1};
      tbl[16] = '{0,0,4'd0,8'h00,1, 1,4'd7,1,8'h21,1,0,1};
      tbl[17] = '{0,0,4'd0,8'h00,1, 0,4'd7,1,8'h21,1,0,2};
      tbl[18] = '{0,0,4'd0,8'h00,1, 0,4'd7,1,8'h21,1,1,2};
      tbl[19] = '{0,0,4'd0,8'h00,0, 0,4'd7,1,8'h21,1,1,2};

      rst = 1; in_valid = 0; in_last = 0; in_dest = 0; in_data = '0; credit_in = 0;
      model_reset();
      #12;
      chk("rst send_out", 256'(send_out), 256'(0));
      chk("rst data_out", data_out, 256'(0));
      chk("rst in_ready", 256'(in_ready), 256'(0));
      chk("rst credit_err", 256'(credit_err), 256'(0));
      chk("rst credits", 256'(dut.credits_q), 256'(MAXC));
      @(negedge clk); rst = 0;
      cycle(0, 0, 4'd0, '0, 0);

      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].v, tbl[i].l, tbl[i].d, 256'(tbl[i].dat), tbl[i].cr);
         chk($sformatf("tbl[%0d] send", i), 256'(send_out), 256'(tbl[i].e_send));
         chk($sformatf("tbl[%0d] dest", i), 256'(dest_out), 256'(tbl[i].e_dest));
         chk($sformatf("tbl[%0d] tail", i), 256'(is_tail_out), 256'(tbl[i].e_tail));
         chk($sformatf("tbl[%0d] data", i), data_out, 256'(tbl[i].e_data));
         chk($sformatf("tbl[%0d] ready", i), 256'(in_ready), 256'(tbl[i].e_ready));
         chk($sformatf("tbl[%0d] err", i), 256'(credit_err), 256'(tbl[i].e_err));
         chk($sformatf("tbl[%0d] credits", i), 256'(dut.credits_q), 256'(tbl[i].e_cred));
      end

      // Streaming with the router returning a credit alongside every send: one flit per cycle.
      sends = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(1, (i % 4) == 3, 4'($urandom_range(0, 15)), {8{$urandom}}, m_send);
         if (i >= 2 && send_out) sends++;
      end
      chk("stream sends", 256'(sends), 256'(18));
      for (int i = 0; i < 4; i++) cycle(0, 0, 4'd0, '0, m_send);

      // Reset in the middle of a 3-flit packet.
      cycle(1, 0, 4'd2, 256'h31, 0);
      @(negedge clk);
      in_valid = 1; in_last = 0; in_dest = 4'd8; in_data = 256'h32;
      #2 rst = 1;
      #1;
      model_reset();
      chk("midrst send_out", 256'(send_out), 256'(0));
      chk("midrst credits", 256'(dut.credits_q), 256'(MAXC));
      chk("midrst fifo_empty", 256'(dut.fifo_empty), 256'(1));
      chk("midrst in_ready", 256'(in_ready), 256'(0));
      @(negedge clk); rst = 0;
      cycle(0, 0, 4'd0, '0, 0);
      cycle(1, 1, 4'd6, 256'h77, 0);
      cycle(0, 0, 4'd0, '0, 0);
      chk("post-rst send", 256'(send_out), 256'(1));
      chk("post-rst dest", 256'(dest_out), 256'(6));
      chk("post-rst data", data_out, 256'h77);
      cycle(0, 0, 4'd0, '0, 1);

      // Random traffic with well-behaved credit returns.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3, 4'($urandom_range(0, 15)),
               {8{$urandom}}, (m_cred < MAXC) && ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
